// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ        = 4'd3;

  // Decimal digits needed to hold the largest unsigned value of the given width.
  function automatic int unsigned min_digits(input int unsigned width);
    logic [63:0] v;
    int unsigned n;
    v = (64'd1 << width) - 64'd1;
    n = 0;
    do begin
      n++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake bus of bin2bcd_seq: producer side (in_*/bin) and consumer side (out_*/bcd).
interface bin2bcd_seq_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   bin;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*DIGITS-1:0]     bcd;
  logic                    sign;
  logic                    overflow;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, sign, overflow
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, sign, overflow
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble chain: add-3 correction, then shift left by one.
module bcd_digit_cell
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       shift_in,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  logic [3:0] adj;

  always_comb begin
    adj        = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ : digit;
    digit_next = {adj[2:0], shift_in};
    carry_out  = adj[3];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Handshaked double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report sign separately.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
) (
  input  logic           CLK,
  input  logic           RST,
  bin2bcd_seq_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [BCD_W-1:0]      dig_q, dig_d, dig_shift;
  logic                  ovf_q, ovf_d;
  logic                  sign_q, sign_d;
  logic [DIGITS:0]       carry;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  sign_load;
  logic                  last_bit;

`ifdef BIN2BCD_SIGNED_EN
  // Magnitude is taken DATA_WIDTH wide so the most-negative value maps to 2^(DATA_WIDTH-1).
  assign sign_load = bus.bin[DATA_WIDTH-1];
  assign load_val  = sign_load ? ({DATA_WIDTH{1'b0}} - bus.bin) : bus.bin;
`else
  assign sign_load = 1'b0;
  assign load_val  = bus.bin;
`endif

  assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign carry[0] = sr_q[DATA_WIDTH-1];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit      (dig_q[4*k +: 4]),
      .shift_in   (carry[k]),
      .digit_next (dig_shift[4*k +: 4]),
      .carry_out  (carry[k+1])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_SHIFT;
      S_SHIFT: if (last_bit)      state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.bcd       = dig_q;
    bus.sign      = sign_q;
    bus.overflow  = ovf_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    sign_d = sign_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sr_d   = load_val;
          dig_d  = '0;
          ovf_d  = 1'b0;
          sign_d = sign_load;
          cnt_d  = '0;
        end
      end
      S_SHIFT: begin
        sr_d  = {sr_q[DATA_WIDTH-2:0], 1'b0};
        dig_d = dig_shift;
        // A bit leaving the top digit means the value needs more digits than we have.
        ovf_d = ovf_q | carry[DIGITS];
        cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      sign_q <= sign_d;
    end
  end

  // Operand shift register is always loaded before use, so it carries no reset.
  always_ff @(posedge CLK) begin
    sr_q <= sr_d;
  end

endmodule
